// File: rtl/sha3_digest_tx_pkg.sv
// ---------------------------------------------------------------------------
// sha3_pkg : shared SHA3 types, digest-length helper and limits
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sha3_pkg;

  typedef enum logic [2:0] {
    SHA3_224 = 3'd0,
    SHA3_256 = 3'd1,
    SHA3_384 = 3'd2,
    SHA3_512 = 3'd3
  } sha3_mode_e;

  typedef logic [63:0]             lane_t;
  typedef logic [4:0][4:0][63:0]   state_t;

  localparam int DIGEST_MAX_BITS = 512;

  function automatic int digest_bits(input logic [2:0] mode);
    case (mode)
      3'd0:    return 224;
      3'd1:    return 256;
      3'd2:    return 384;
      default: return 512;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha3_digest_tx_if.sv
// ---------------------------------------------------------------------------
// sha3_digest_tx_if : AXI-Stream digest output bundle
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sha3_digest_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    TVALID;
  logic                    TREADY;
  logic [DATA_WIDTH-1:0]   TDATA;
  logic [DATA_WIDTH/8-1:0] TKEEP;
  logic                    TLAST;
  logic [2:0]              TUSER;

  modport master (output TVALID, TDATA, TKEEP, TLAST, TUSER, input TREADY);
  modport slave  (input  TVALID, TDATA, TKEEP, TLAST, TUSER, output TREADY);
endinterface

`default_nettype wire

// File: rtl/sha3_digest_tx_word_sel.sv
// ---------------------------------------------------------------------------
// digest_word_sel : picks one beat from the digest snapshot and builds TKEEP
// rev 1.0 -- SHA3_DIGEST_BYTESWAP_EN reverses byte order within the beat
// ---------------------------------------------------------------------------
`default_nettype none

module digest_word_sel
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DIGEST_MAX_BITS-1:0] snap_i,
  input  logic [5:0]                 idx_i,
  input  logic                       last_i,
  input  logic [9:0]                 bits_i,
  output logic [DATA_WIDTH-1:0]      data_o,
  output logic [DATA_WIDTH/8-1:0]    keep_o
);
  localparam int NB = DATA_WIDTH / 8;

  int          rem;
  int          nvalid;
  logic [NB-1:0] keep_le;

  always_comb begin
    rem     = int'(bits_i) % DATA_WIDTH;
    nvalid  = (last_i && rem != 0) ? rem / 8 : NB;
    keep_le = '0;
    for (int b = 0; b < NB; b++) begin
      keep_le[b] = (b < nvalid);
    end
  end

  // Lane order is already digest byte order, so beat j starts at bit j*DW.
  for (genvar b = 0; b < NB; b++) begin : g_byte
`ifdef SHA3_DIGEST_BYTESWAP_EN
    localparam int D = NB - 1 - b;
`else
    localparam int D = b;
`endif
    assign data_o[8*D +: 8] = keep_le[b] ? snap_i[int'(idx_i)*DATA_WIDTH + 8*b +: 8] : 8'h00;
    assign keep_o[D]        = keep_le[b];
  end

endmodule

`default_nettype wire

// File: rtl/sha3_digest_tx.sv
// ---------------------------------------------------------------------------
// sha3_digest_tx : snapshots Keccak lanes 0-7 and streams the digest on AXIS
// rev 1.0 -- optional SHA3_DIGEST_BYTESWAP_EN (see digest_word_sel)
// ---------------------------------------------------------------------------
`default_nettype none

module sha3_digest_tx
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             start,
  input  logic [2:0]       mode,
  input  state_t           state_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  sha3_digest_tx_if.master m_axis
);
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } fsm_e;

  fsm_e                       state_q, state_d;
  logic [DIGEST_MAX_BITS-1:0] snap_q, snap_d;
  logic [5:0]                 idx_q, idx_d;
  logic [2:0]                 mode_q, mode_d;
  logic [DATA_WIDTH-1:0]      tdata_q, tdata_d;
  logic [DATA_WIDTH/8-1:0]    tkeep_q, tkeep_d;
  logic                       tlast_q, tlast_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       last_d;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic [DATA_WIDTH/8-1:0]    sel_keep;

  function automatic logic [5:0] last_idx(input logic [2:0] m);
    return 6'((digest_bits(m) + DATA_WIDTH - 1) / DATA_WIDTH - 1);
  endfunction

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (mode <= 3'd3) begin
            state_d = SEND;
            idx_d   = '0;
            mode_d  = mode;
            for (int i = 0; i < 8; i++) begin
              snap_d[64*i +: 64] = state_in[i % 5][i / 5];
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (m_axis.TREADY) begin
          if (idx_q == last_idx(mode_q)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last_d = (idx_d == last_idx(mode_d));

  digest_word_sel #(.DATA_WIDTH(DATA_WIDTH)) u_sel (
    .snap_i (snap_d),
    .idx_i  (idx_d),
    .last_i (last_d),
    .bits_i (10'(digest_bits(mode_d))),
    .data_o (sel_data),
    .keep_o (sel_keep)
  );

  // Beat outputs are registered from the next-state select so they change
  // only on a handshake and read as zero whenever the stream is idle.
  always_comb begin
    tdata_d = '0;
    tkeep_d = '0;
    tlast_d = 1'b0;
    if (state_d == SEND) begin
      tdata_d = sel_data;
      tkeep_d = sel_keep;
      tlast_d = last_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      mode_q  <= '0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tlast_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      tdata_q <= tdata_d;
      tkeep_q <= tkeep_d;
      tlast_q <= tlast_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign m_axis.TVALID = (state_q == SEND);
  assign m_axis.TDATA  = tdata_q;
  assign m_axis.TKEEP  = tkeep_q;
  assign m_axis.TLAST  = tlast_q;
  assign m_axis.TUSER  = mode_q;
  assign busy          = (state_q == SEND);
  assign done          = done_q;
  assign err           = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sha3_digest_tx.sv
// ---------------------------------------------------------------------------
// tb_sha3_digest_tx : directed checks of the digest streamer at DW=16 and DW=64
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sha3_digest_tx;
  import sha3_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start16 = 1'b0;
  logic       start64 = 1'b0;
  logic [2:0] mode = 3'd0;
  state_t     st_in, st_a, st_b;
  logic       busy16, done16, err16;
  logic       busy64, done64, err64;
  int         n_pass = 0;
  int         n_total = 0;

  sha3_digest_tx_if #(.DATA_WIDTH(16)) ax16 ();
  sha3_digest_tx_if #(.DATA_WIDTH(64)) ax64 ();

  sha3_digest_tx #(.DATA_WIDTH(16)) dut16 (
    .ACLK(clk), .ARESETn(rst_n), .start(start16), .mode(mode), .state_in(st_in),
    .busy(busy16), .done(done16), .err(err16), .m_axis(ax16)
  );

  sha3_digest_tx #(.DATA_WIDTH(64)) dut64 (
    .ACLK(clk), .ARESETn(rst_n), .start(start64), .mode(mode), .state_in(st_in),
    .busy(busy64), .done(done64), .err(err64), .m_axis(ax64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SHA3-256 at DW=16 from st_a; optional stall and start-while-busy beats.
  task automatic run16(input int stall_beat, input int busy_start_beat);
    logic [15:0] exp_d;
    mode = 3'd1; st_in = st_a; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk("s256_busy_rise", {63'd0, busy16}, 64'd1);
    for (int j = 0; j < 16; j++) begin
      exp_d = {8'(2*j+1), 8'(2*j)};
      chk($sformatf("s256_b%0d_data", j), {48'd0, ax16.TDATA}, {48'd0, exp_d});
      chk($sformatf("s256_b%0d_last", j), {63'd0, ax16.TLAST}, (j == 15) ? 64'd1 : 64'd0);
      chk($sformatf("s256_b%0d_keep", j), {62'd0, ax16.TKEEP}, 64'd3);
      chk($sformatf("s256_b%0d_user", j), {61'd0, ax16.TUSER}, 64'd1);
      if (j == stall_beat) begin
        ax16.TREADY = 1'b0;
        repeat (3) begin
          tick();
          chk("stall_valid", {63'd0, ax16.TVALID}, 64'd1);
          chk("stall_data",  {48'd0, ax16.TDATA},  {48'd0, exp_d});
          chk("stall_last",  {63'd0, ax16.TLAST},  64'd0);
        end
        ax16.TREADY = 1'b1;
      end
      if (j == busy_start_beat) begin
        mode = 3'd3; st_in = st_b; start16 = 1'b1;
      end
      tick();
      start16 = 1'b0;
      if (j == busy_start_beat) chk("busy_start_err", {63'd0, err16}, 64'd0);
    end
    chk("s256_done",      {63'd0, done16},      64'd1);
    chk("s256_busy_fall", {63'd0, busy16},      64'd0);
    chk("s256_idle_valid",{63'd0, ax16.TVALID}, 64'd0);
    chk("s256_idle_data", {48'd0, ax16.TDATA},  64'd0);
    tick();
    chk("s256_done_pulse",{63'd0, done16},      64'd0);
  endtask

  logic [63:0] e64_data [4];
  logic [7:0]  e64_keep [4];
  logic [63:0] lane;

  initial begin
    for (int i = 0; i < 25; i++) begin
      lane = 64'hA5A5_0000_0000_0000 | 64'(i);
      if (i < 8) for (int b = 0; b < 8; b++) lane[8*b +: 8] = 8'(8*i + b);
      st_a[i % 5][i / 5] = lane;
      st_b[i % 5][i / 5] = ~lane;
    end
    st_in = st_a;
    ax16.TREADY = 1'b1;
    ax64.TREADY = 1'b1;
    e64_data = '{64'h0706050403020100, 64'h0F0E0D0C0B0A0908,
                 64'h1716151413121110, 64'h000000001B1A1918};
    e64_keep = '{8'hFF, 8'hFF, 8'hFF, 8'h0F};

    repeat (2) tick();
    chk("rst_valid", {63'd0, ax16.TVALID}, 64'd0);
    chk("rst_data",  {48'd0, ax16.TDATA},  64'd0);
    chk("rst_keep",  {62'd0, ax16.TKEEP},  64'd0);
    chk("rst_last",  {63'd0, ax16.TLAST},  64'd0);
    chk("rst_user",  {61'd0, ax16.TUSER},  64'd0);
    chk("rst_flags", {61'd0, busy16, done16, err16}, 64'd0);
    rst_n = 1'b1;
    tick();

    run16(-1, 5);
    run16(3, -1);

    mode = 3'd5; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    chk("m5_err",   {63'd0, err16},       64'd1);
    chk("m5_valid", {63'd0, ax16.TVALID}, 64'd0);
    chk("m5_busy",  {63'd0, busy16},      64'd0);
    tick();
    chk("m5_err_pulse", {63'd0, err16},   64'd0);
    chk("m5_busy2",     {63'd0, busy16},  64'd0);

    mode = 3'd0; st_in = st_a; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("s224_b%0d_data", j), ax64.TDATA, e64_data[j]);
      chk($sformatf("s224_b%0d_keep", j), {56'd0, ax64.TKEEP}, {56'd0, e64_keep[j]});
      chk($sformatf("s224_b%0d_last", j), {63'd0, ax64.TLAST}, (j == 3) ? 64'd1 : 64'd0);
      chk($sformatf("s224_b%0d_user", j), {61'd0, ax64.TUSER}, 64'd0);
      tick();
    end
    chk("s224_done", {63'd0, done64}, 64'd1);
    chk("s224_busy", {63'd0, busy64}, 64'd0);

    mode = 3'd3; st_in = st_a; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    repeat (5) tick();
    chk("s512_b5_data", {48'd0, ax16.TDATA}, 64'h0B0A);
    chk("s512_b5_user", {61'd0, ax16.TUSER}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, ax16.TVALID}, 64'd0);
    chk("mid_rst_data",  {48'd0, ax16.TDATA},  64'd0);
    chk("mid_rst_keep",  {62'd0, ax16.TKEEP},  64'd0);
    chk("mid_rst_last",  {63'd0, ax16.TLAST},  64'd0);
    chk("mid_rst_user",  {61'd0, ax16.TUSER},  64'd0);
    chk("mid_rst_flags", {61'd0, busy16, done16, err16}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run16(-1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
